// File: rtl/fxp_requant_pkg.sv
// Shared configuration and types for the fxp_requant streaming requantizer.
// The data width follows the WORD_SIZE define when one is supplied and is 16 otherwise.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package fxp_requant_pkg;

    localparam int WORD_SIZE = `WORD_SIZE;
    localparam int QW        = 4;

    localparam logic signed [WORD_SIZE-1:0] MAX_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [WORD_SIZE-1:0] MAX_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

    // Largest legal fractional-bit count, in field width and one bit wider for compares.
    localparam logic [QW-1:0] F_MAX   = QW'(WORD_SIZE - 1);
    localparam logic [QW:0]   F_MAX_W = {1'b0, F_MAX};

    typedef struct packed {
        logic                          valid;
        logic signed [2*WORD_SIZE-1:0] data;
        logic                          rnd;
        logic [QW-1:0]                 f;
        logic                          cfg_err;
    } stage_t;

endpackage

// File: rtl/fxp_sat_round.sv
// fxp_sat_round: combinational round-and-saturate from 2*WORD_SIZE bits to WORD_SIZE bits.
// The round bit is added only when FXP_ROUND_EN is defined; otherwise it is ignored.
module fxp_sat_round
    import fxp_requant_pkg::*;
(
    input  logic signed [2*WORD_SIZE-1:0] data_i,
    input  logic                          rnd_i,
    output logic signed [WORD_SIZE-1:0]   data_o,
    output logic                          sat_o
);

`ifdef FXP_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    logic signed [2*WORD_SIZE-1:0] sum;
    logic [WORD_SIZE:0]            top;

    always_comb begin
        sum    = data_i + $signed({{(2*WORD_SIZE-1){1'b0}}, rnd_i & ROUND_EN});
        // The value fits only if every bit above the output sign bit repeats it.
        top    = sum[2*WORD_SIZE-1:WORD_SIZE-1];
        sat_o  = (top != '0) && (top != '1);
        data_o = sum[WORD_SIZE-1:0];
        if (sat_o) begin
            data_o = sum[2*WORD_SIZE-1] ? MAX_NEG : MAX_POS;
        end
    end

endmodule

// File: rtl/fxp_requant.sv
// fxp_requant: two-stage streaming requantizer (align, then round/saturate) with valid/ready.
// Right-shift rounding is enabled by defining FXP_ROUND_EN; the default build truncates.
module fxp_requant
    import fxp_requant_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WORD_SIZE-1:0] DataIn,
    input  logic [QW-1:0]               QI_in,
    input  logic [QW-1:0]               QF_in,
    input  logic [QW-1:0]               QF_target,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WORD_SIZE-1:0] DataOut,
    output logic [QW-1:0]               QI_out,
    output logic [QW-1:0]               QF_out,
    output logic                        Sat,
    output logic                        CfgErr,
    input  logic                        ClearCount,
    output logic [15:0]                 SatCount
);

    stage_t                        s1_q, s1_d;
    logic                          out_valid_q;
    logic signed [WORD_SIZE-1:0]   data_q;
    logic [QW-1:0]                 qi_q, qf_q;
    logic                          sat_q, cfg_q;
    logic [15:0]                   cnt_q, cnt_d;
    logic                          s2_free;
    logic signed [2*WORD_SIZE-1:0] ext;
    logic signed [QW:0]            shift;
    logic [QW:0]                   rsh;
    logic signed [WORD_SIZE-1:0]   sr_data;
    logic                          sr_sat;
    logic                          unused_qi;

    assign unused_qi = ^QI_in;
    assign s2_free   = !out_valid_q || out_ready;
    assign in_ready  = !rst && (!s1_q.valid || s2_free);

    // Stage 1: clamp target format and align the sample to it
    always_comb begin
        s1_d         = '0;
        s1_d.valid   = in_valid;
        s1_d.cfg_err = (QF_target == '0) || ({1'b0, QF_target} > F_MAX_W);
        s1_d.f       = s1_d.cfg_err ? F_MAX : QF_target;
        shift        = $signed({1'b0, s1_d.f}) - $signed({1'b0, QF_in});
        rsh          = $unsigned(-shift);
        ext          = {{WORD_SIZE{DataIn[WORD_SIZE-1]}}, DataIn};
        if (shift > 0) begin
            s1_d.data = ext << shift[QW-1:0];
        end else if (shift < 0) begin
            s1_d.data = ext >>> rsh;
            s1_d.rnd  = ext[rsh - (QW+1)'(1)];
        end else begin
            s1_d.data = ext;
        end
    end

    // Stage 2: round, saturate and hold until accepted
    fxp_sat_round u_sat_round (
        .data_i (s1_q.data),
        .rnd_i  (s1_q.rnd),
        .data_o (sr_data),
        .sat_o  (sr_sat)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (ClearCount) begin
            cnt_d = '0;
        end else if (out_valid_q && out_ready && sat_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q.valid  <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            qi_q        <= '0;
            qf_q        <= '0;
            sat_q       <= 1'b0;
            cfg_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (in_ready) begin
                s1_q <= s1_d;
            end
            if (s2_free) begin
                out_valid_q <= s1_q.valid;
                if (s1_q.valid) begin
                    data_q <= sr_data;
                    sat_q  <= sr_sat;
                    qf_q   <= s1_q.f;
                    qi_q   <= QW'(WORD_SIZE) - s1_q.f;
                    cfg_q  <= s1_q.cfg_err;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign DataOut   = data_q;
    assign QI_out    = qi_q;
    assign QF_out    = qf_q;
    assign Sat       = sat_q;
    assign CfgErr    = cfg_q;
    assign SatCount  = cnt_q;

endmodule

// File: doc/fxp_requant.md
Name: fxp_requant

Overview:
- Streaming fixed-point requantizer. Consumes samples tagged with a dynamic Q format (QI_in/QF_in), as produced by the adder/accumulator tree of the matrix multiplier.
- Converts each sample back to a caller-selected target format, with rounding and saturation.
- Sits between the accumulator output and the result store, so every stored element shares one common Q format.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- WORD_SIZE, default 16 (from `WORD_SIZE in config.v): data width in bits. Legal range 4..16.
- QW, default 4: width of the Q-format fields.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- DataIn  in  WORD_SIZE  signed two's-complement input sample.
- QI_in  in  QW  integer bits of DataIn; informational, carried through.
- QF_in  in  QW  fractional bits of DataIn.
- QF_target  in  QW  requested fractional bits of the output; sampled together with the data.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output sample.
- DataOut  out  WORD_SIZE  requantized signed sample.
- QI_out  out  QW  WORD_SIZE minus the effective QF_target.
- QF_out  out  QW  effective QF_target.
- Sat  out  1  this output sample was saturated.
- CfgErr  out  1  QF_target was out of range for this sample and was clamped.
- ClearCount  in  1  synchronous clear of SatCount.
- SatCount  out  16  count of saturated samples delivered; sticks at 0xFFFF.

Behaviour:
- Reset values (next edge with rst=1): out_valid=0, DataOut=0, QI_out=0, QF_out=0, Sat=0, CfgErr=0, SatCount=0.
- During reset in_ready=0; it returns to 1 on the first cycle after reset.
- Reset mid-operation discards all in-flight samples.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a clock edge.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational from out_ready.
  - Once out_valid=1, DataOut, QI_out, QF_out, Sat and CfgErr stay stable until accepted.
  - No sample is lost, duplicated or reordered under any pattern of back-pressure.
  - Latency is 2 cycles from input acceptance to out_valid.
  - Sustained throughput is 1 sample per cycle while out_ready=1.
- Stage 1 (align):
  - Effective target F = QF_target, clamped to 1..WORD_SIZE-1; CfgErr=1 if clamped.
  - shift = F - QF_in, signed QW+1 bits.
  - DataIn is sign-extended to 2*WORD_SIZE bits.
  - shift>0: left shift by shift.
  - shift<0: arithmetic right shift by -shift, keeping the round bit (the last bit shifted out).
  - shift=0: pass through.
- Stage 2 (round/saturate):
  - Add the round bit (round half up, toward +inf).
  - If the result does not fit in WORD_SIZE signed bits, saturate: 0x7FFF..F for positive, 0x800..0 for negative, and set Sat=1.
  - QF_out=F; QI_out=WORD_SIZE-F.
- SatCount:
  - Increments by 1 when a sample with Sat=1 is accepted downstream (out_valid & out_ready); holds at 0xFFFF.
  - ClearCount has priority over an increment in the same cycle.
- QF_target is captured per sample. Changing it mid-stream affects only later accepted samples.
- QI_in does not affect DataOut.

Optional Feature:
- Macro FXP_ROUND_EN.
- Defined: round-half-up on right shifts, as described above.
- Undefined: plain truncation toward -inf. The round bit is ignored, and right shifts can never saturate.
- Left-shift saturation is identical in both builds.

Decomposition:
- Shared package / config include holds:
  - WORD_SIZE and QW;
  - the saturation constants MAX_POS and MAX_NEG;
  - the pipeline-stage record typedef: valid, data (2*WORD_SIZE), round bit, F, CfgErr.
- One natural sub-module, fxp_sat_round: combinational round-and-saturate from 2*WORD_SIZE bits down to WORD_SIZE bits, reused by future accumulator write-back paths.

Test Plan:
- Left shift: DataIn=0x0180, QF_in=8, QF_target=12, out_ready=1 -> two cycles later DataOut=0x1800, QI_out=4, QF_out=12, Sat=0.
- Positive/negative saturation: DataIn=0x7F00 / 0x8100, QF_in=8, QF_target=12 -> DataOut=0x7FFF / 0x8000, Sat=1, SatCount=2 after both are accepted.
- Rounding: DataIn=0x0003 and 0xFFFD, QF_in=8, QF_target=7 -> with FXP_ROUND_EN 0x0002 and 0xFFFF; without it 0x0001 and 0xFFFE.
- Config error: QF_target=0 -> clamped to F=15, CfgErr=1, QI_out=1.
- Back-pressure:
  - Offer 4 back-to-back samples with out_ready=0 for 5 cycles -> in_ready drops after 2 samples are accepted, and DataOut stays stable.
  - Then raise out_ready -> all 4 samples are delivered in order, with no loss or duplicate.
- Reset and clear:
  - Assert rst with 2 samples in flight -> next edge out_valid=0, SatCount=0, and nothing is delivered afterwards.
  - ClearCount coinciding with a saturated accept -> SatCount=0.
